// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/memory transaction sequencer shared by fetch and load/store ports
// Round-robin between two requesters; Moore outputs decoded from registered state.
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              mar_write,
  output logic              mar_out_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mdr_load,
  output logic              ack0,
  output logic              ack1,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_last;
  logic              r_grant;
  logic              r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              w_pick1;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign w_pick1 = req1 && (!req0 || !r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_op    <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_grant <= w_pick1;
            r_last  <= w_pick1;
            r_addr  <= w_pick1 ? addr1 : addr0;
            r_op    <= w_pick1 & we1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cnt   <= LP_CNT_INIT;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign bus_drive  = (r_state == S_ADDR);
  assign mar_write  = (r_state == S_ADDR);
  assign mar_out_en = (r_state == S_ACCESS);
  assign mem_rd     = (r_state == S_ACCESS) && !r_op;
  assign mem_wr     = (r_state == S_ACCESS) && r_op;
  assign mdr_load   = mem_rd && (r_cnt == 4'd0);
  assign ack0       = (r_state == S_DONE) && !r_grant;
  assign ack1       = (r_state == S_DONE) && r_grant;
  assign bus_out    = bus_drive ? r_addr : {ADDR_W{1'bz}};

endmodule
